// File: rtl/data_mem_responder_pkg.sv
// Shared ramControl access codes and the access-size decode used by the data memory responder.
package data_mem_responder_pkg;

    localparam logic [2:0] RAM_W  = 3'b000;
    localparam logic [2:0] RAM_B  = 3'b001;
    localparam logic [2:0] RAM_H  = 3'b010;
    localparam logic [2:0] RAM_BU = 3'b101;
    localparam logic [2:0] RAM_HU = 3'b110;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } access_size_e;

    // Codes 011, 100 and 111 have no meaning and fall back to a word access.
    function automatic access_size_e decode_size(input logic [2:0] ctl);
        case (ctl)
            RAM_B, RAM_BU: return SIZE_BYTE;
            RAM_H, RAM_HU: return SIZE_HALF;
            RAM_W:         return SIZE_WORD;
            default:       return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU load/store data bus between the control unit/datapath (master) and the data RAM (slave).
interface data_mem_responder_if;

    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic        busWe;
    logic        busRe;
    logic [2:0]  ramControl;
    logic        errClr;
    logic [31:0] busRData;
    logic        busRValid;
    logic        busErr;
    logic        errSticky;

    modport master (
        output busAddr, busWData, busWe, busRe, ramControl, errClr,
        input  busRData, busRValid, busErr, errSticky
    );

    modport slave (
        input  busAddr, busWData, busWe, busRe, ramControl, errClr,
        output busRData, busRValid, busErr, errSticky
    );

endinterface

// File: rtl/data_mem_responder_byte_lane_ram.sv
// Four independent 8-bit lanes forming a 32-bit word RAM: synchronous per-lane write,
// asynchronous read of the addressed word.
module byte_lane_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter bit INIT_ZERO   = 1'b1,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] word_idx,
    input  logic [3:0]    lane_we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        if (INIT_ZERO) begin : g_zero
            logic [7:0] mem [DEPTH_WORDS] = '{default: 8'h00};

            always_ff @(posedge clk) begin
                if (lane_we[lane]) mem[word_idx] <= wdata[8*lane +: 8];
            end

            assign rdata[8*lane +: 8] = mem[word_idx];
        end else begin : g_raw
            logic [7:0] mem [DEPTH_WORDS];

            always_ff @(posedge clk) begin
                if (lane_we[lane]) mem[word_idx] <= wdata[8*lane +: 8];
            end

            assign rdata[8*lane +: 8] = mem[word_idx];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressable data RAM endpoint for the CPU load/store bus: merges partial stores,
// returns extended load data one cycle later and flags misaligned/out-of-range accesses.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter bit INIT_ZERO   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, RESP} state_e;

    state_e       state_q, state_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         rvalid_q, rvalid_d;
    logic         err_q, err_d;
    logic         sticky_q, sticky_d;

    access_size_e size;
    logic [AW-1:0] word_idx;
    logic [1:0]   offset;
    logic         out_of_range, misaligned, rejected;
    logic         strobe, load_go, store_go;
    logic [3:0]   lane_we;
    logic [31:0]  lane_wdata, ram_word, load_ext;
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;

    assign size         = decode_size(bus.ramControl);
    assign word_idx     = bus.busAddr[AW+1:2];
    assign offset       = bus.busAddr[1:0];
    assign out_of_range = bus.busAddr >= 32'(DEPTH_WORDS * 4);
    assign misaligned   = ((size == SIZE_HALF) && offset[0]) ||
                          ((size == SIZE_WORD) && (offset != 2'b00));
    assign rejected     = out_of_range || misaligned;
    assign strobe       = bus.busWe || bus.busRe;
    assign load_go      = bus.busRe && !bus.busWe;
    assign store_go     = reset && bus.busWe && !rejected;

    // Narrow store data is replicated so every enabled lane sees its own byte.
    always_comb begin
        lane_we    = 4'hF;
        lane_wdata = bus.busWData;
        case (size)
            SIZE_BYTE: begin
                lane_we    = 4'b0001 << offset;
                lane_wdata = {4{bus.busWData[7:0]}};
            end
            SIZE_HALF: begin
                lane_we    = 4'b0011 << offset;
                lane_wdata = {2{bus.busWData[15:0]}};
            end
            default: ;
        endcase
        if (!store_go) lane_we = 4'h0;
    end

    byte_lane_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_ZERO  (INIT_ZERO)
    ) u_ram (
        .clk     (clk),
        .word_idx(word_idx),
        .lane_we (lane_we),
        .wdata   (lane_wdata),
        .rdata   (ram_word)
    );

    always_comb begin
        sel_byte = ram_word[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? ram_word[31:16] : ram_word[15:0];
        case (size)
            SIZE_BYTE: load_ext = bus.ramControl[2] ? {24'h0, sel_byte}
                                                    : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: load_ext = bus.ramControl[2] ? {16'h0, sel_half}
                                                    : {{16{sel_half[15]}}, sel_half};
            default:   load_ext = ram_word;
        endcase
    end

    // A load colliding with a store is dropped and reported as an error.
    always_comb begin
        state_d  = strobe ? RESP : IDLE;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        sticky_d = sticky_q && !bus.errClr;
        if (load_go) begin
            rvalid_d = 1'b1;
            rdata_d  = rejected ? 32'h0 : load_ext;
        end
        if (strobe && (rejected || (bus.busWe && bus.busRe))) err_d = 1'b1;
        if (err_d) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.busRData  = rdata_q;
    assign bus.busRValid = rvalid_q && (state_q == RESP);
    assign bus.busErr    = err_q && (state_q == RESP);
    assign bus.errSticky = sticky_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed load/store scenarios with literal
// expectations, then randomized traffic compared every cycle against a byte-array model.
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 256;
    localparam int MEM_BYTES   = DEPTH_WORDS * 4;

    logic clk;
    logic reset_n;
    int   assert_count;
    int   fail_count;

    data_mem_responder_if bus_if();

    data_mem_responder #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_ZERO  (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a flat byte array, accesses described by size and byte address.
    logic [7:0]  model_mem [MEM_BYTES];
    logic        mem_ready = 1'b0;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    logic        exp_err;
    logic        exp_sticky;

    always @(posedge clk) begin
        int          size;
        logic        bad;
        logic        we;
        logic        re;
        logic [31:0] a;
        logic [31:0] val;
        logic [31:0] mask;
        if (!mem_ready) begin
            for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
            mem_ready = 1'b1;
        end
        a  = bus_if.busAddr;
        we = bus_if.busWe;
        re = bus_if.busRe;
        case (bus_if.ramControl)
            3'b001, 3'b101: size = 1;
            3'b010, 3'b110: size = 2;
            default:        size = 4;
        endcase
        bad       = (a >= 32'(MEM_BYTES)) || ((a % 32'(size)) != 32'd0);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (!reset_n) begin
            exp_rdata  = 32'h0;
            exp_sticky = 1'b0;
        end else begin
            if (we && !bad) begin
                for (int i = 0; i < size; i++) model_mem[a + i] = bus_if.busWData[8*i +: 8];
            end
            if (re && !we) begin
                exp_valid = 1'b1;
                if (bad) begin
                    exp_rdata = 32'h0;
                end else begin
                    val = 32'h0;
                    for (int i = 0; i < size; i++) val = val | (32'(model_mem[a + i]) << (8 * i));
                    if (size < 4 && !bus_if.ramControl[2] && val[8*size-1]) begin
                        mask = (32'h1 << (8 * size)) - 32'h1;
                        val  = val | ~mask;
                    end
                    exp_rdata = val;
                end
            end
            exp_err    = (we || re) && (bad || (we && re));
            exp_sticky = exp_err || (exp_sticky && !bus_if.errClr);
        end
    end

    task automatic compareModel();
        assert_count++;
        if (bus_if.busRData !== exp_rdata || bus_if.busRValid !== exp_valid ||
            bus_if.busErr !== exp_err || bus_if.errSticky !== exp_sticky) begin
            fail_count++;
            $display("[TB] FAIL model_cycle @%0t: got rdata=%h valid=%b err=%b sticky=%b, required rdata=%h valid=%b err=%b sticky=%b",
                     $time, bus_if.busRData, bus_if.busRValid, bus_if.busErr, bus_if.errSticky,
                     exp_rdata, exp_valid, exp_err, exp_sticky);
        end
    endtask

    // Waits for a falling edge, checks the previous cycle's outputs, then drives the next cycle.
    task automatic applyStimulus(input logic rst_n, input logic we, input logic re,
                                 input logic [2:0] ctl, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic clr);
        @(negedge clk);
        compareModel();
        reset_n           = rst_n;
        bus_if.busWe      = we;
        bus_if.busRe      = re;
        bus_if.ramControl = ctl;
        bus_if.busAddr    = addr;
        bus_if.busWData   = wdata;
        bus_if.errClr     = clr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] rdata, input logic valid,
                               input logic err, input logic sticky);
        assert_count++;
        if (bus_if.busRData !== rdata || bus_if.busRValid !== valid ||
            bus_if.busErr !== err || bus_if.errSticky !== sticky) begin
            fail_count++;
            $display("[TB] FAIL %s: got rdata=%h valid=%b err=%b sticky=%b, required rdata=%h valid=%b err=%b sticky=%b",
                     name, bus_if.busRData, bus_if.busRValid, bus_if.busErr, bus_if.errSticky,
                     rdata, valid, err, sticky);
        end
    endtask

    task automatic idle(input logic clr);
        applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, clr);
    endtask

    task automatic store(input logic [2:0] ctl, input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b1, 1'b0, ctl, addr, wdata, 1'b0);
    endtask

    task automatic load(input logic [2:0] ctl, input logic [31:0] addr);
        applyStimulus(1'b1, 1'b0, 1'b1, ctl, addr, 32'h0, 1'b0);
    endtask

    initial begin
        int pick;
        logic [31:0] addr;
        assert_count      = 0;
        fail_count        = 0;
        reset_n           = 1'b0;
        bus_if.busWe      = 1'b0;
        bus_if.busRe      = 1'b0;
        bus_if.ramControl = 3'b000;
        bus_if.busAddr    = 32'h0;
        bus_if.busWData   = 32'h0;
        bus_if.errClr     = 1'b0;

        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        checkOutput("reset_state", 32'h0, 1'b0, 1'b0, 1'b0);

        load(3'b000, 32'h40);
        store(3'b000, 32'h10, 32'hDEADBEEF);
        checkOutput("init_zero", 32'h0, 1'b1, 1'b0, 1'b0);
        load(3'b000, 32'h10);
        idle(1'b0);
        checkOutput("lw_after_sw", 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        store(3'b001, 32'h11, 32'h0000007F);
        checkOutput("rvalid_one_cycle", 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        load(3'b000, 32'h10);
        load(3'b001, 32'h13);
        checkOutput("lw_after_sb", 32'hDEAD7FEF, 1'b1, 1'b0, 1'b0);
        load(3'b101, 32'h13);
        checkOutput("lb", 32'hFFFFFFDE, 1'b1, 1'b0, 1'b0);
        load(3'b010, 32'h12);
        checkOutput("lbu", 32'h000000DE, 1'b1, 1'b0, 1'b0);
        load(3'b110, 32'h12);
        checkOutput("lh", 32'hFFFFDEAD, 1'b1, 1'b0, 1'b0);
        store(3'b000, 32'h20, 32'hCAFEF00D);
        checkOutput("lhu", 32'h0000DEAD, 1'b1, 1'b0, 1'b0);

        store(3'b010, 32'h21, 32'h0000BEEF);
        load(3'b000, 32'h22);
        checkOutput("sh_misaligned", 32'h0000DEAD, 1'b0, 1'b1, 1'b1);
        load(3'b000, 32'h20);
        checkOutput("lw_misaligned", 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("mem_unchanged", 32'hCAFEF00D, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        checkOutput("err_clr", 32'hCAFEF00D, 1'b0, 1'b0, 1'b0);

        load(3'b000, 32'h400);
        idle(1'b0);
        checkOutput("out_of_range", 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b0);
        checkOutput("oor_clr", 32'h0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b1, 3'b000, 32'h30, 32'h12345678, 1'b0);
        idle(1'b0);
        checkOutput("same_cycle_we_re", 32'h0, 1'b0, 1'b1, 1'b1);
        load(3'b000, 32'h30);
        idle(1'b0);
        checkOutput("lw_after_collision", 32'h12345678, 1'b1, 1'b0, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 32'h10, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h10, 32'h11111111, 1'b0);
        checkOutput("reset_drops_load", 32'h0, 1'b0, 1'b0, 1'b0);
        load(3'b000, 32'h10);
        checkOutput("reset_outputs", 32'h0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("post_reset_contents", 32'hDEAD7FEF, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick <= 6)      addr = 32'($urandom_range(0, 63));
            else if (pick == 7) addr = 32'($urandom_range(32'h3F8, 32'h407));
            else if (pick == 8) addr = 32'($urandom_range(0, MEM_BYTES - 1));
            else                addr = $urandom;
            applyStimulus($urandom_range(0, 99) >= 2,
                          $urandom_range(0, 99) < 35,
                          $urandom_range(0, 99) < 45,
                          3'($urandom_range(0, 7)),
                          addr,
                          $urandom,
                          $urandom_range(0, 99) < 5);
        end
        idle(1'b0);
        idle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Byte-addressable data RAM that answers the CPU's load/store data bus. It is the memory-side endpoint driven by the multicycle control unit's `busWe`/`ramControl` signals and the datapath's address and write data. It decodes the `ramControl` width/sign code, merges partial stores into the addressed word, and returns sign- or zero-extended load data with one-cycle registered latency. It also flags misaligned and out-of-range accesses.

## Interface
Parameters:
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two.
- `INIT_ZERO`, 1: 1 means the array is zeroed at elaboration; reset never clears the array.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset; one clock, sampled on `clk`.
- `busAddr`  in  32  byte address.
- `busWData`  in  32  store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- `busWe`  in  1  store strobe, one cycle per store.
- `busRe`  in  1  load strobe, one cycle per load.
- `ramControl`  in  3  access code: 000 word, 001 byte signed, 010 half signed, 101 byte unsigned, 110 half unsigned.
- `errClr`  in  1  clears `errSticky`.
- `busRData`  out  32  extended load data; holds its value until the next accepted load.
- `busRValid`  out  1  one-cycle pulse, `busRData` updated.
- `busErr`  out  1  one-cycle pulse, the previous cycle's access was rejected.
- `errSticky`  out  1  latched OR of all `busErr` pulses since the last clear.

## Operation
- Word index = `busAddr[log2(DEPTH_WORDS)+1:2]`. Byte offset = `busAddr[1:0]`.
- Out of range: `busAddr >= DEPTH_WORDS*4`.
- Misaligned: a half access with `busAddr[0]=1`, or a word access with `busAddr[1:0]!=0`.
- Stores:
  - Lane enables: byte → lane = offset; half → lanes {offset+1, offset}; word → all four lanes.
  - Write data is replicated onto the lanes: byte → `{4{wdata[7:0]}}`, half → `{2{wdata[15:0]}}`.
  - `ramControl[2]` is ignored on stores.
  - Illegal code (011, 100, 111): treated as a word access.
- Loads:
  - Select the addressed byte or half from the word.
  - Sign-extend if `ramControl[2]=0`, else zero-extend.
  - Word accesses pass through unchanged.
  - Illegal codes are treated as word.
- Rejected access (misaligned or out of range):
  - Store: no lane is written.
  - Load: `busRData` is loaded with 0 and `busRValid` still pulses.
  - Both: `busErr` pulses.
- Simultaneous `busWe` and `busRe`:
  - The store executes.
  - The load is dropped: no `busRValid`, `busRData` unchanged.
  - `busErr` pulses.
- Response FSM, states IDLE and RESP:
  - IDLE→RESP on any accepted strobe.
  - RESP→IDLE if no strobe this cycle.
  - RESP→RESP on back-to-back strobes.
  - `busRValid` and `busErr` are registered outputs, asserted only in RESP and only for the access that caused the entry.
- `errSticky`:
  - Set on any `busErr`.
  - If `errClr` and a new error occur in the same cycle, set wins.

## Timing
- Store: array updated at the rising edge where `busWe=1`. A load issued the very next cycle returns the new data.
- Load: strobe at edge N; `busRData`/`busRValid` valid after edge N+1. This matches the control unit's L_MEM→L_WB sequence.
- Back-to-back loads are supported at one per cycle with one-cycle latency.
- Reset (`reset=0` at an edge):
  - FSM goes to IDLE.
  - `busRData`=0, `busRValid`=0, `busErr`=0, `errSticky`=0.
  - A load in flight is discarded, with no pulse after reset.
  - A store strobed in the same cycle as reset is not performed.
  - Array contents are preserved.
- Wrap-around: none. Addresses beyond the top are errors, not aliased.

## Structure
- The `ramControl` codes go in the shared defines file, next to the opcode and ALU macros, so the control unit and this block share one definition: `RAM_W`=000, `RAM_B`=001, `RAM_H`=010, `RAM_BU`=101, `RAM_HU`=110.
- FSM state enum (IDLE, RESP) is local to this block.
- One sub-module, `byte_lane_ram`:
  - Four `DEPTH_WORDS`×8 arrays with per-lane write enable.
  - Synchronous write; asynchronous read of the addressed word.
  - The top level registers the extended result.

## Test plan
- Reset, then `sw 0xDEADBEEF`@0x10, then `lw`@0x10 → next cycle `busRData`=0xDEADBEEF, `busRValid`=1 for exactly one cycle.
- After the store above, `sb 0x7F`@0x11 then `lw`@0x10 → 0xDEAD7FEF. Then `lb`@0x13 → 0xFFFFFFDE; `lbu`@0x13 → 0x000000DE; `lh`@0x12 → 0xFFFFDEAD; `lhu`@0x12 → 0x0000DEAD.
- `sh`@0x21 and `lw`@0x22 → each gives `busErr` pulse, memory unchanged, load returns 0, `errSticky`=1. `errClr` → `errSticky`=0.
- `lw`@`DEPTH_WORDS*4` (0x400 with default depth) → `busRData`=0, `busErr`=1, `busRValid`=1.
- Same-cycle `busWe`+`busRe` @0x30 with wdata 0x12345678 → word written, `busErr`=1, `busRValid`=0. A later `lw`@0x30 returns 0x12345678.
- `lw` strobed with `reset=0` asserted on the following edge → no `busRValid`, all outputs 0. A post-reset `lw` returns the pre-reset contents.
